// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and constants for the memory port arbiter.
//   - bus width typedefs for instruction / data paths
//   - arb_state_e : arbiter FSM states
//   - owner_e     : which requester owns the in-flight transaction
//   - ExCode      : RISC-V exception codes returned with responses
package mem_port_arbiter_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] InstAddrBus;
    typedef logic [XLEN-1:0] InstBus;
    typedef logic [XLEN-1:0] MemAddrBus;
    typedef logic [XLEN-1:0] MemBus;
    typedef logic [7:0]      ExCode;
    typedef logic [3:0]      MemBe;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RSP  = 2'd2,
        ERR  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam ExCode EXC_INST_MISALIGN  = 8'd0;
    localparam ExCode EXC_INST_FAULT     = 8'd1;
    localparam ExCode EXC_LOAD_MISALIGN  = 8'd4;
    localparam ExCode EXC_LOAD_FAULT     = 8'd5;
    localparam ExCode EXC_STORE_MISALIGN = 8'd6;
    localparam ExCode EXC_STORE_FAULT    = 8'd7;

    // Access-fault code for a bus error or response timeout.
    function automatic ExCode fault_code(input owner_e owner, input logic we);
        if (owner == OWN_IF) begin
            return EXC_INST_FAULT;
        end
        return we ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
    endfunction

endpackage

// File: rtl/mem_align_check.sv
// mem_align_check
// Combinational alignment check of the request about to be granted.
//   i_is_fetch   : 1 = instruction fetch, 0 = LSU access
//   i_we         : LSU store flag (ignored for fetch)
//   i_be         : LSU byte enables (ignored for fetch)
//   i_addr_lo    : address bits [1:0]
//   o_misaligned : access must not go to memory
//   o_exc        : misalign ExCode for this kind of access
module mem_align_check
    import mem_port_arbiter_pkg::*;
(
    input  logic       i_is_fetch,
    input  logic       i_we,
    input  MemBe       i_be,
    input  logic [1:0] i_addr_lo,
    output logic       o_misaligned,
    output ExCode      o_exc
);

    always_comb begin
        o_misaligned = 1'b0;
        if (i_is_fetch) begin
            o_misaligned = (i_addr_lo != 2'b00);
        end else begin
            // Word must be word aligned, half-word must be half aligned;
            // single-byte and other strobe patterns are always accepted.
            case (i_be)
                4'hF:       o_misaligned = (i_addr_lo != 2'b00);
                4'h3, 4'hC: o_misaligned = i_addr_lo[0];
                default:    o_misaligned = 1'b0;
            endcase
        end

        if (i_is_fetch) begin
            o_exc = EXC_INST_MISALIGN;
        end else if (i_we) begin
            o_exc = EXC_STORE_MISALIGN;
        end else begin
            o_exc = EXC_LOAD_MISALIGN;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one 32-bit memory port between instruction fetch (IF) and the
// load/store unit (LSU). One outstanding transaction at a time.
//   IF side  : if_req/if_addr/if_flush in; if_gnt/if_rvalid/if_rdata/if_exc out
//   LSU side : lsu_req/we/be/addr/wdata in; lsu_gnt/rvalid/rdata/exc out
//   Memory   : mem_req/we/be/addr/wdata/abort out; mem_gnt/rvalid/rdata/err in
//   dbg_state: current FSM state
// Handshake: a requester holds *_req with stable payload; *_gnt pulses for
// one cycle in IDLE and the payload is captured on that edge. Exactly one
// *_rvalid pulse later returns the response (rdata/exc valid only with it).
// Downstream: mem_req with payload is held until mem_gnt; the response is
// the first mem_rvalid in RSP.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req,
    input  InstAddrBus if_addr,
    input  logic       if_flush,
    output logic       if_gnt,
    output logic       if_rvalid,
    output InstBus     if_rdata,
    output ExCode      if_exc,
    input  logic       lsu_req,
    input  logic       lsu_we,
    input  MemBe       lsu_be,
    input  MemAddrBus  lsu_addr,
    input  MemBus      lsu_wdata,
    output logic       lsu_gnt,
    output logic       lsu_rvalid,
    output MemBus      lsu_rdata,
    output ExCode      lsu_exc,
    output logic       mem_req,
    output logic       mem_we,
    output MemBe       mem_be,
    output MemAddrBus  mem_addr,
    output MemBus      mem_wdata,
    input  logic       mem_gnt,
    input  logic       mem_rvalid,
    input  MemBus      mem_rdata,
    input  logic       mem_err,
    output logic       mem_abort,
    output arb_state_e dbg_state
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    owner_e        r_owner;
    logic [SW-1:0] r_streak;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    MemBe          r_be;
    MemAddrBus     r_addr;
    MemBus         r_wdata;
    ExCode         r_mis_exc;
    logic          r_drop;

    logic          w_idle;
    logic          w_pick_if;
    logic          w_gnt_if;
    logic          w_gnt_lsu;
    logic          w_misaligned;
    ExCode         w_mis_exc;
    logic          w_timeout;
    logic          w_rsp_fire;
    ExCode         w_rsp_exc;
    MemBus         w_rsp_data;
    logic          w_flush_hit;
    logic          w_drop;

    // Grants are also gated by rst_n so every output is 0 while in reset.
    assign w_idle    = (r_state == IDLE) && rst_n;
    assign w_pick_if = if_req && (!lsu_req || (r_streak == STREAK_MAX));
    assign w_gnt_if  = w_idle && w_pick_if;
    assign w_gnt_lsu = w_idle && lsu_req && !w_pick_if;

    mem_align_check u_align (
        .i_is_fetch   (w_pick_if),
        .i_we         (lsu_we),
        .i_be         (lsu_be),
        .i_addr_lo    (w_pick_if ? if_addr[1:0] : lsu_addr[1:0]),
        .o_misaligned (w_misaligned),
        .o_exc        (w_mis_exc)
    );

    // Counter holds cycles spent in RSP minus one; the last allowed cycle
    // is TIMEOUT cycles after the mem_gnt edge.
    assign w_timeout  = (r_state == RSP) && !mem_rvalid && (r_cnt == CNT_LAST);
    assign w_rsp_fire = (r_state == ERR) ||
                        ((r_state == RSP) && (mem_rvalid || w_timeout));

    // A flush in the response cycle itself also suppresses that response.
    assign w_flush_hit = if_flush && (r_owner == OWN_IF) && (r_state != IDLE);
    assign w_drop      = r_drop || w_flush_hit;

    always_comb begin
        w_state_nxt = r_state;
        if_gnt      = w_gnt_if;
        lsu_gnt     = w_gnt_lsu;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_be      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_abort   = w_timeout;
        w_rsp_exc   = '0;
        w_rsp_data  = '0;

        case (r_state)
            IDLE: begin
                if (w_gnt_if || w_gnt_lsu) begin
                    w_state_nxt = w_misaligned ? ERR : ADDR;
                end
            end
            ADDR: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_be    = r_be;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                if (mem_gnt) begin
                    w_state_nxt = RSP;
                end
            end
            RSP: begin
                if (mem_rvalid) begin
                    w_state_nxt = IDLE;
                    if (mem_err) begin
                        w_rsp_exc = fault_code(r_owner, r_we);
                    end else begin
                        w_rsp_data = mem_rdata;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                    w_rsp_exc   = fault_code(r_owner, r_we);
                end
            end
            ERR: begin
                w_state_nxt = IDLE;
                w_rsp_exc   = r_mis_exc;
            end
            default: w_state_nxt = IDLE;
        endcase

        if_rvalid  = w_rsp_fire && (r_owner == OWN_IF) && !w_drop;
        lsu_rvalid = w_rsp_fire && (r_owner == OWN_LSU);
        if_rdata   = if_rvalid  ? w_rsp_data : '0;
        if_exc     = if_rvalid  ? w_rsp_exc  : '0;
        lsu_rdata  = lsu_rvalid ? w_rsp_data : '0;
        lsu_exc    = lsu_rvalid ? w_rsp_exc  : '0;
    end

    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= OWN_IF;
            r_streak  <= '0;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_mis_exc <= '0;
            r_drop    <= 1'b0;
        end else begin
            if (w_gnt_if) begin
                r_owner   <= OWN_IF;
                r_streak  <= '0;
                r_we      <= 1'b0;
                r_be      <= 4'hF;
                r_addr    <= if_addr;
                r_wdata   <= '0;
                r_mis_exc <= w_mis_exc;
            end else if (w_gnt_lsu) begin
                r_owner   <= OWN_LSU;
                r_we      <= lsu_we;
                r_be      <= lsu_be;
                r_addr    <= lsu_addr;
                r_wdata   <= lsu_wdata;
                r_mis_exc <= w_mis_exc;
                // Only contested LSU wins count toward IF starvation.
                if (if_req && (r_streak != STREAK_MAX)) begin
                    r_streak <= r_streak + 1'b1;
                end
            end

            if ((r_state == ADDR) && mem_gnt) begin
                r_cnt <= '0;
            end else if (r_state == RSP) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_state_nxt == IDLE) begin
                r_drop <= 1'b0;
            end else if (w_flush_hit) begin
                r_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int STARVE = 4;
    localparam int TMO    = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       if_req = 0, if_flush = 0;
    logic [31:0] if_addr = '0;
    logic       lsu_req = 0, lsu_we = 0;
    logic [3:0] lsu_be = '0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic       mem_gnt = 0, mem_rvalid = 0, mem_err = 0;
    logic [31:0] mem_rdata = '0;

    logic        if_gnt, if_rvalid, lsu_gnt, lsu_rvalid;
    logic [31:0] if_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic [7:0]  if_exc, lsu_exc;
    logic        mem_req, mem_we, mem_abort;
    logic [3:0]  mem_be;
    arb_state_e  dbg_state;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_exc(if_exc),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
        .lsu_rdata(lsu_rdata), .lsu_exc(lsu_exc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .mem_abort(mem_abort),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int streak   = 0;   // contested LSU wins since the last IF grant

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, {30'd0, if_gnt, lsu_gnt}, 0);
        check({tag, "_rv"}, {30'd0, if_rvalid, lsu_rvalid}, 0);
        check({tag, "_rdata"}, if_rdata | lsu_rdata, 0);
        check({tag, "_exc"}, {16'd0, if_exc, lsu_exc}, 0);
        check({tag, "_mreq"}, {29'd0, mem_req, mem_we, mem_abort}, 0);
        check({tag, "_mbus"}, mem_addr | mem_wdata | {28'd0, mem_be}, 0);
    endtask

    // Downstream payload must be presented and held while waiting for mem_gnt.
    task automatic check_addr(input bit exp_if, input logic [31:0] ia, input bit we,
                              input logic [3:0] be, input logic [31:0] la, input logic [31:0] wd);
        check("mem_req", mem_req, 1);
        check("mem_we", mem_we, exp_if ? 1'b0 : we);
        check("mem_be", mem_be, exp_if ? 4'hF : be);
        check("mem_addr", mem_addr, exp_if ? ia : la);
        if (!exp_if) check("mem_wdata", mem_wdata, wd);
        check("gnt_busy", {if_gnt, lsu_gnt}, 0);
        check("rv_busy", {if_rvalid, lsu_rvalid}, 0);
        check("abort_addr", mem_abort, 0);
    endtask

    // One complete transaction: request, arbitration, memory behaviour, response.
    // The loser's request is withdrawn after the grant.
    task automatic run_txn(input bit rq_if, input bit rq_lsu, input logic [31:0] ia,
                           input bit we, input logic [3:0] be, input logic [31:0] la,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int gnt_dly, input int rsp_dly, input bit err,
                           input bit no_rsp, input bit flush, input bit noise,
                           output bit won_if);
        bit exp_if, mis, drop, faulty, last;
        logic [7:0] code;
        int kmax;

        exp_if = rq_if && (!rq_lsu || streak == STARVE);
        mis = exp_if ? (ia[1:0] != 2'b00)
                     : ((be == 4'hF && la[1:0] != 2'b00) || ((be == 4'h3 || be == 4'hC) && la[0]));
        drop = flush && exp_if;

        // cycle 0: IDLE, request presented
        @(negedge clk);
        if_flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = '0;
        if_req = rq_if; if_addr = ia;
        lsu_req = rq_lsu; lsu_we = we; lsu_be = be; lsu_addr = la; lsu_wdata = wd;
        #1;
        check("rv_idle", {if_rvalid, lsu_rvalid}, 0);
        check("mreq_idle", mem_req, 0);
        check("if_gnt", if_gnt, exp_if);
        check("lsu_gnt", lsu_gnt, !exp_if);
        won_if = if_gnt;
        if (exp_if) streak = 0;
        else if (rq_if && streak < STARVE) streak++;

        // cycle 1: ADDR or ERR
        @(negedge clk);
        if_req = 0; lsu_req = 0;
        if (noise) begin mem_rvalid = 1; mem_err = 1; mem_rdata = 32'hDEAD_BEEF; end
        if (flush) if_flush = 1;
        if (!mis) mem_gnt = (gnt_dly == 0);
        #1;
        if (mis) begin
            code = exp_if ? 8'd0 : (we ? 8'd6 : 8'd4);
            check("mis_mreq", mem_req, 0);
            check("mis_rv", exp_if ? if_rvalid : lsu_rvalid, !drop);
            check("mis_other_rv", exp_if ? lsu_rvalid : if_rvalid, 0);
            check("mis_exc", exp_if ? if_exc : lsu_exc, drop ? 8'd0 : code);
            check("mis_rdata", exp_if ? if_rdata : lsu_rdata, 0);
            return;
        end
        check_addr(exp_if, ia, we, be, la, wd);
        for (int g = 1; g <= gnt_dly; g++) begin
            @(negedge clk);
            if_flush = 0; mem_rvalid = 0; mem_err = 0;
            mem_gnt = (g == gnt_dly);
            #1;
            check_addr(exp_if, ia, we, be, la, wd);
        end

        // RSP: k counts cycles after the mem_gnt edge
        kmax = no_rsp ? TMO : rsp_dly + 1;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            mem_gnt = 0; if_flush = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = '0;
            last = (k == kmax);
            if (last && !no_rsp) begin mem_rvalid = 1; mem_err = err; mem_rdata = rd; end
            #1;
            check("rsp_mreq", mem_req, 0);
            check("abort", mem_abort, last && no_rsp);
            if (last) begin
                faulty = err || no_rsp;
                code = faulty ? (exp_if ? 8'd1 : (we ? 8'd7 : 8'd5)) : 8'd0;
                check("rsp_rv", exp_if ? if_rvalid : lsu_rvalid, !drop);
                check("rsp_other_rv", exp_if ? lsu_rvalid : if_rvalid, 0);
                check("rsp_exc", exp_if ? if_exc : lsu_exc, drop ? 8'd0 : code);
                check("rsp_rdata", exp_if ? if_rdata : lsu_rdata, (drop || faulty) ? 32'd0 : rd);
            end else begin
                check("rsp_wait_rv", {if_rvalid, lsu_rvalid}, 0);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit won;
        logic [3:0] be_tab [7];
        be_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

        // reset state
        #1;
        check_all_zero("reset");
        check("reset_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1;

        // single fetch, zero-wait grant, response two cycles after mem_gnt
        run_txn(1, 0, 32'h100, 0, 4'hF, 0, 0, 32'h0000_0013, 0, 1, 0, 0, 0, 0, won);

        // contention: LSU x4 then IF, repeating
        for (int i = 0; i < 10; i++) begin
            run_txn(1, 1, 32'h200 + 32'(i * 4), 0, 4'hF, 32'h3000 + 32'(i * 4), 0,
                    32'(i), 0, 0, 0, 0, 0, 0, won);
            check("contend_order", won, (i % 5 == 4));
        end

        // misaligned store and fetch
        run_txn(0, 1, 0, 1, 4'hF, 32'h1002, 32'h55, 0, 0, 0, 0, 0, 0, 0, won);
        run_txn(1, 0, 32'h102, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, won);
        run_txn(0, 1, 0, 0, 4'hC, 32'h2001, 0, 0, 0, 0, 0, 0, 0, 0, won);

        // bus error on a load
        run_txn(0, 1, 0, 0, 4'hF, 32'h4000, 0, 32'h1234_5678, 1, 0, 1, 0, 0, 0, won);

        // timeouts: load then store
        run_txn(0, 1, 0, 0, 4'hF, 32'h5000, 0, 0, 0, 0, 0, 1, 0, 0, won);
        run_txn(0, 1, 0, 1, 4'hF, 32'h5004, 32'hA5A5, 0, 1, 0, 0, 1, 0, 0, won);

        // flushed fetch, then a normal fetch proceeds
        run_txn(1, 0, 32'h300, 0, 4'hF, 0, 0, 32'hCAFE, 1, 2, 0, 0, 1, 0, won);
        run_txn(1, 0, 32'h304, 0, 4'hF, 0, 0, 32'hBEEF, 0, 0, 0, 0, 0, 0, won);

        // reset asserted asynchronously while in ADDR
        @(negedge clk);
        lsu_req = 1; lsu_we = 1; lsu_be = 4'hF; lsu_addr = 32'h6000; lsu_wdata = 32'h77;
        @(negedge clk);
        lsu_req = 0;
        #1;
        check("pre_rst_mreq", mem_req, 1);
        #2;
        rst_n = 0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1;
        streak = 0;
        #1;
        check_all_zero("post_rst");

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            bit ri, rl, w, e, nr, fl, nz;
            logic [31:0] ia, la;
            ri = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            if (!ri && !rl) ri = 1;
            ia = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) ia[1:0] = 2'($urandom_range(1, 3));
            la = $urandom;
            if ($urandom_range(0, 1) == 0) la[1:0] = 2'b00;
            w  = 1'($urandom_range(0, 1));
            e  = ($urandom_range(0, 5) == 0);
            nr = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 5) == 0);
            nz = ($urandom_range(0, 5) == 0);
            run_txn(ri, rl, ia, w, be_tab[$urandom_range(0, 6)], la, $urandom, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 3), e, nr, fl, nz, won);
        end

        @(negedge clk);
        mem_rvalid = 0; mem_err = 0; mem_gnt = 0; if_flush = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single 32-bit memory port between instruction fetch (IF, read-only) and the load/store unit (LSU, read/write, byte strobes).
- Allows one outstanding transaction and routes each response to the requester that owns it.
- Pre-checks alignment, detects response timeouts, and returns RISC-V exception codes (ExCode) to the requester.
- Sits between the IF/MEM pipeline stages and the memory/bus interface.

Parameters:
- STARVE_LIMIT, 4: consecutive contested LSU wins allowed before IF is forced a grant.
- TIMEOUT, 255: maximum cycles from mem_gnt to mem_rvalid before an access fault is returned.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  InstAddrBus  fetch address
- if_flush  in  1  discard the in-flight fetch response
- if_gnt  out  1  fetch request accepted
- if_rvalid  out  1  fetch response valid
- if_rdata  out  InstBus  fetched instruction
- if_exc  out  ExCode  exception code, valid with if_rvalid
- lsu_req  in  1  data request
- lsu_we  in  1  1 = store
- lsu_be  in  4  byte enables
- lsu_addr  in  MemAddrBus  data address
- lsu_wdata  in  MemBus  store data
- lsu_gnt  out  1  data request accepted
- lsu_rvalid  out  1  data response valid
- lsu_rdata  out  MemBus  load data
- lsu_exc  out  ExCode  exception code, valid with lsu_rvalid
- mem_req  out  1  downstream request
- mem_we  out  1  downstream write enable
- mem_be  out  4  downstream byte enables
- mem_addr  out  MemAddrBus  downstream address
- mem_wdata  out  MemBus  downstream write data
- mem_gnt  in  1  downstream accepts the address phase
- mem_rvalid  in  1  downstream response valid
- mem_rdata  in  MemBus  downstream read data
- mem_err  in  1  downstream bus error, valid with mem_rvalid
- mem_abort  out  1  one-cycle pulse: memory must drop the pending transaction

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all outputs 0; owner, streak and timeout counters 0.
  - Reset mid-transaction abandons it silently; no response is produced.
- States: IDLE, ADDR, RSP, ERR.
- IDLE:
  - Arbitration: LSU wins over IF unless streak==STARVE_LIMIT and if_req=1.
  - Grant: if_gnt/lsu_gnt asserts combinationally, one cycle, in IDLE only. Requester payload is latched at that edge.
  - Streak counter:
    - Increments on an LSU grant while if_req=1.
    - Clears on any IF grant.
    - Saturates at STARVE_LIMIT.
- Alignment check (at grant):
  - IF: addr[1:0]!=0 is misaligned.
  - LSU: misaligned when be is 4'hF with addr[1:0]!=0, or be is 4'h3/4'hC with addr[0]!=0.
  - A misaligned access goes to ERR, never drives mem_req, and responds the next cycle with rdata=0. Codes: IF 8'd0, load 8'd4, store 8'd6.
- ADDR:
  - mem_req=1 with latched we/be/addr/wdata, held stable until mem_gnt. IF accesses drive we=0, be=4'hF.
  - On mem_gnt, go to RSP and clear the timeout counter.
  - First mem_req is the cycle after the grant.
- RSP:
  - The counter increments each cycle.
  - On mem_rvalid: pulse the owner's rvalid for one cycle in the same cycle, rdata=mem_rdata. exc=0, or on mem_err 1/5/7 (fetch/load/store). Return to IDLE.
  - If the counter reaches TIMEOUT without mem_rvalid: pulse mem_abort, respond with the fault code and rdata=0, return to IDLE.
- ERR: one-cycle response pulse, then IDLE.
- Back-to-back: a new grant is possible in the first IDLE cycle, so minimum throughput is one transaction per 3 cycles (zero-wait memory).
- if_flush:
  - Sets a sticky drop flag when asserted while IF owns ADDR/RSP/ERR.
  - The IF response is then consumed but if_rvalid is suppressed. The flag clears on return to IDLE.
  - if_flush in IDLE has no effect. The transaction is never cancelled downstream.
- mem_rvalid outside RSP is ignored.
- Response outputs (rdata/exc) are 0 whenever the matching rvalid=0.

Decomposition:
- Shared package gets:
  - an arb_state_e enum (IDLE/ADDR/RSP/ERR);
  - an owner_e enum (OWN_IF/OWN_LSU);
  - ExCode constants EXC_INST_MISALIGN=0, EXC_INST_FAULT=1, EXC_LOAD_MISALIGN=4, EXC_LOAD_FAULT=5, EXC_STORE_MISALIGN=6, EXC_STORE_FAULT=7;
  - typedef MemBe (logic [3:0]).
- One natural sub-module: mem_align_check (combinational address/be check → misaligned flag + ExCode).

Test Plan:
- Single fetch: if_req, addr 0x100, mem_gnt immediate, mem_rvalid 2 cycles later with rdata 0x00000013 → if_gnt at t0, mem_req at t1, if_rvalid with 0x00000013, if_exc=0.
- Contention: if_req and lsu_req held continuously, STARVE_LIMIT=4 → grant order LSU,LSU,LSU,LSU,IF, repeating.
- Misaligned: LSU store be=4'hF, addr 0x1002 → mem_req never asserts; lsu_rvalid one cycle after grant, lsu_exc=6. Fetch addr 0x102 → if_exc=0 error response.
- Bus error: load with mem_rvalid and mem_err=1 → lsu_rvalid, lsu_exc=5, lsu_rdata=0.
- Timeout: TIMEOUT=8, mem_gnt but no mem_rvalid → mem_abort and lsu_rvalid with exc 5 (load) / 7 (store) exactly 8 cycles after mem_gnt.
- Flush and reset: if_flush during RSP → no if_rvalid, next grant proceeds. rst_n low during ADDR → mem_req drops asynchronously, all outputs 0.
